// File: rtl/pipe_stage_reg.sv
// One-deep pipeline stage register with valid/allow_in handshake, stall and flush.
// Define PIPE_STAGE_SKID_EN to add a skid entry so allow_in comes straight from a flop.
module pipe_stage_reg #(
  parameter int unsigned       DATA_W   = 64,
  parameter logic [DATA_W-1:0] RST_DATA = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              allow_in,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              next_allow_in,
  input  logic              stall,
  input  logic              flush
);

  logic              r_main_valid;
  logic [DATA_W-1:0] r_main_data;
  logic              w_ready_go;
  logic              w_in_fire;

  assign w_ready_go = !stall;
  assign w_in_fire  = in_valid && allow_in;

  // A stalled or flushed beat is never offered downstream.
  assign out_valid  = r_main_valid && w_ready_go && !flush;
  assign out_data   = r_main_data;

`ifdef PIPE_STAGE_SKID_EN
  logic              r_skid_valid;
  logic [DATA_W-1:0] r_skid_data;
  logic              w_out_fire;
  logic              w_main_ld;

  assign w_out_fire = out_valid && next_allow_in;
  assign allow_in   = !r_skid_valid;
  assign w_main_ld  = w_out_fire || !r_main_valid;

  // Main refills from skid first; a beat arriving while main is held parks in skid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_main_valid <= 1'b0;
      r_main_data  <= RST_DATA;
      r_skid_valid <= 1'b0;
      r_skid_data  <= RST_DATA;
    end else if (flush) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (w_main_ld) begin
      if (r_skid_valid) begin
        r_main_valid <= 1'b1;
        r_main_data  <= r_skid_data;
        r_skid_valid <= 1'b0;
      end else begin
        r_main_valid <= in_valid;
        if (w_in_fire) begin
          r_main_data <= in_data;
        end
      end
    end else if (w_in_fire) begin
      r_skid_valid <= 1'b1;
      r_skid_data  <= in_data;
    end
  end
`else
  assign allow_in = !r_main_valid || (w_ready_go && next_allow_in);

  // Loading valid on every accept lets a bubble clear a drained stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_main_valid <= 1'b0;
      r_main_data  <= RST_DATA;
    end else if (flush) begin
      r_main_valid <= 1'b0;
    end else if (allow_in) begin
      r_main_valid <= in_valid;
      if (w_in_fire) begin
        r_main_data <= in_data;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg; honours PIPE_STAGE_SKID_EN when defined.
module tb_pipe_stage_reg;

  localparam int unsigned       DW   = 64;
  localparam logic [DW-1:0]     RSTD = 64'h0000_0000_5A5A_5A5A;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          allow_in;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          next_allow_in;
  logic          stall;
  logic          flush;

  int            n_checks = 0;
  int            n_errors = 0;
  logic [DW-1:0] sb[$];
  logic          last_acc;

  pipe_stage_reg #(.DATA_W(DW), .RST_DATA(RSTD)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .allow_in(allow_in), .out_valid(out_valid), .out_data(out_data),
    .next_allow_in(next_allow_in), .stall(stall), .flush(flush)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One cycle: drive at negedge, sample before the next posedge, update the scoreboard.
  task automatic cyc(input logic v, input logic [63:0] d, input logic nai,
                     input logic st, input logic fl);
    logic [63:0] exp;
    @(negedge clk);
    in_valid = v; in_data = d; next_allow_in = nai; stall = st; flush = fl;
    #1;
    check("out_valid", 64'(out_valid), 64'(sb.size() > 0 && !st && !fl));
`ifdef PIPE_STAGE_SKID_EN
    check("allow_in", 64'(allow_in), 64'(sb.size() < 2));
`else
    check("allow_in", 64'(allow_in), 64'(sb.size() == 0 || (!st && nai)));
`endif
    if (out_valid && nai) begin
      check("sb_nonempty", 64'(sb.size() > 0), 64'd1);
      if (sb.size() > 0) begin
        exp = sb.pop_front();
        check("out_data", out_data, exp);
      end
    end
    last_acc = v && allow_in;
    if (fl) sb.delete();
    else if (last_acc) sb.push_back(d);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() > 0; i++) cyc(1'b0, 64'd0, 1'b1, 1'b0, 1'b0);
    check("drain_empty", 64'(sb.size()), 64'd0);
    cyc(1'b0, 64'd0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    logic        pend;
    int          k;
    logic        v, nai, st, fl;
    logic [63:0] ctr;

    reset = 1'b1; in_valid = 1'b0; in_data = '0; next_allow_in = 1'b0;
    stall = 1'b0; flush = 1'b0;
    #3;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_allow_in", 64'(allow_in), 64'd1);
    check("rst_out_data", out_data, RSTD);
    #5 reset = 1'b0;

    // Streaming 1..8 back to back.
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b1, 64'(i), 1'b1, 1'b0, 1'b0);
      check("stream_valid", 64'(out_valid), 64'(i > 1));
    end
    cyc(1'b0, 64'd0, 1'b1, 1'b0, 1'b0);
    check("stream_last", out_data, 64'd8);
    drain();

    // Stall holding 0x10 with 0x11 waiting.
    cyc(1'b1, 64'h10, 1'b1, 1'b0, 1'b0);
    pend = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(pend, 64'h11, 1'b1, 1'b1, 1'b0);
      if (last_acc) pend = 1'b0;
      check("stall_ov_low", 64'(out_valid), 64'd0);
    end
    cyc(pend, 64'h11, 1'b1, 1'b0, 1'b0);
    if (last_acc) pend = 1'b0;
    check("stall_release_ov", 64'(out_valid), 64'd1);
    check("stall_release_data", out_data, 64'h10);
    for (int i = 0; i < 10 && pend; i++) begin
      cyc(1'b1, 64'h11, 1'b1, 1'b0, 1'b0);
      if (last_acc) pend = 1'b0;
    end
    check("stall_next_sent", 64'(pend), 64'd0);
    drain();

    // Bubble between beats.
    cyc(1'b1, 64'h30, 1'b1, 1'b0, 1'b0);
    check("bub_c0", 64'(out_valid), 64'd0);
    cyc(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
    check("bub_c1", 64'(out_valid), 64'd1);
    cyc(1'b1, 64'h31, 1'b1, 1'b0, 1'b0);
    check("bub_c2", 64'(out_valid), 64'd0);
    cyc(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
    check("bub_c3", 64'(out_valid), 64'd1);
    check("bub_c3_data", out_data, 64'h31);
    cyc(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
    check("bub_c4", 64'(out_valid), 64'd0);

    // Flush with main (and skid) occupied and a beat arriving.
    cyc(1'b1, 64'h20, 1'b1, 1'b0, 1'b0);
`ifdef PIPE_STAGE_SKID_EN
    cyc(1'b1, 64'h21, 1'b0, 1'b0, 1'b0);
    check("flush_skid_acc", 64'(last_acc), 64'd1);
`endif
    cyc(1'b1, 64'h22, 1'b1, 1'b0, 1'b1);
    cyc(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
    check("flush_ov", 64'(out_valid), 64'd0);
    check("flush_allow_in", 64'(allow_in), 64'd1);
    drain();

`ifdef PIPE_STAGE_SKID_EN
    // Backpressure: three beats offered, only two fit.
    k = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(k < 3, 64'h40 + 64'(k), 1'b0, 1'b0, 1'b0);
      if (last_acc) k++;
    end
    check("bp_accepted", 64'(k), 64'd2);
    check("bp_allow_in_low", 64'(allow_in), 64'd0);
    cyc(k < 3, 64'h40 + 64'(k), 1'b1, 1'b0, 1'b0);
    if (last_acc) k++;
    check("bp_first_out", out_data, 64'h40);
    check("bp_allow_in_hold", 64'(allow_in), 64'd0);
    cyc(k < 3, 64'h40 + 64'(k), 1'b1, 1'b0, 1'b0);
    if (last_acc) k++;
    check("bp_allow_in_reopen", 64'(allow_in), 64'd1);
    check("bp_all_sent", 64'(k), 64'd3);
    drain();
`endif

    // Reset mid-stream with 0xA5 held.
    cyc(1'b1, 64'hA5, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
    check("pre_rst_data", out_data, 64'hA5);
    reset = 1'b1;
    #1;
    check("mid_rst_ov", 64'(out_valid), 64'd0);
    check("mid_rst_data", out_data, RSTD);
    check("mid_rst_allow", 64'(allow_in), 64'd1);
    sb.delete();
    #1 reset = 1'b0;
    cyc(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
    check("post_rst_ov", 64'(out_valid), 64'd0);

    // Random traffic against the scoreboard.
    ctr = 64'h1000;
    for (int i = 0; i < 400; i++) begin
      v   = ($urandom_range(0, 3) != 0);
      nai = ($urandom_range(0, 3) != 0);
      st  = ($urandom_range(0, 7) == 0);
      fl  = ($urandom_range(0, 31) == 0);
      cyc(v, ctr, nai, st, fl);
      if (last_acc) ctr++;
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 64, payload width in bits.
REQ-002 SHALL have parameter RST_DATA, default 0, payload register value after reset.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  upstream beat present.
REQ-006 SHALL have port in_data  input  DATA_W  upstream payload.
REQ-007 SHALL have port allow_in  output  1  stage accepts a beat this cycle.
REQ-008 SHALL have port out_valid  output  1  beat offered downstream.
REQ-009 SHALL have port out_data  output  DATA_W  payload of the oldest held beat.
REQ-010 SHALL have port next_allow_in  input  1  downstream accepts this cycle.
REQ-011 SHALL have port stall  input  1  hold the oldest beat (hazard, e.g. load-use); ready_go = !stall.
REQ-012 SHALL have port flush  input  1  discard all held beats (redirect).

Function
REQ-013 SHALL define in_fire = in_valid && allow_in and out_fire = out_valid && next_allow_in.
REQ-014 SHALL drive out_valid = main_valid && !stall && !flush, so a flushed or stalled beat is never offered.
REQ-015 SHALL present out_data = main_data whenever main_valid = 1; the value is don't-care otherwise.
REQ-016 SHALL give a latency of exactly 1 cycle: a beat accepted at edge N is offered after edge N (cycle N+1).
REQ-017 SHALL preserve beat order; no beat is duplicated or dropped except by flush.
REQ-018 SHALL load main_valid <= in_valid on every cycle where main accepts, so that a bubble clears a drained stage.
REQ-019 SHALL write main_data only when in_fire loads main; the payload is held otherwise.
REQ-020 SHALL, while stall = 1, keep main_valid and main_data unchanged, and SHALL leave next_allow_in without effect.
REQ-021 SHALL, on flush = 1, clear every valid bit at the next edge; a beat arriving in the same cycle is dropped. Flush SHALL take priority over stall, load and transfer.
REQ-022 SHALL, on simultaneous out_fire and in_fire, replace the departing beat with the new one with no bubble, sustaining 1 beat per cycle.

Reset
REQ-023 SHALL, on reset assertion, clear main_valid and skid_valid and set main_data and skid_data to RST_DATA immediately, without waiting for a clock.
REQ-024 SHALL hold outputs during reset at: out_valid = 0, out_data = RST_DATA, allow_in = 1.
REQ-025 SHALL abandon any beat held mid-operation on reset; the first edge after deassertion SHALL behave as from empty.

Configuration
REQ-026 SHALL compile the skid buffer in or out with macro PIPE_STAGE_SKID_EN.
REQ-027 SHALL, without PIPE_STAGE_SKID_EN, implement a single entry with allow_in = !main_valid || (!stall && next_allow_in). This is a combinational path from next_allow_in and stall.
REQ-028 SHALL, with PIPE_STAGE_SKID_EN, implement a second entry (skid) with allow_in = !skid_valid, driven purely from a register.
REQ-029 SHALL, in skid mode, route an in_fire to skid when main stays occupied (main_valid && !out_fire); otherwise the beat goes to main.
REQ-030 SHALL, in skid mode, move skid into main on out_fire while skid_valid = 1, clearing skid_valid; allow_in reasserts the following cycle.
REQ-031 SHALL, in skid mode, keep latency, ordering, stall, flush and reset behaviour identical to REQ-014..REQ-025; throughput SHALL remain 1 beat per cycle.

Verification
REQ-032 SHALL cover reset mid-stream: assert reset with main holding 0xA5 (no clock edge) -> out_valid = 0 at once; out_data = RST_DATA; allow_in = 1.
REQ-033 SHALL cover streaming: in_valid = 1 on 8 consecutive cycles with data 1..8, next_allow_in = 1 -> out_valid high for 8 consecutive cycles, out_data 1..8, first one cycle after first accept.
REQ-034 SHALL cover stall: stall = 1 for 3 cycles while holding 0x10 -> out_valid = 0 for those cycles; 0x10 appears once after release, and the next beat 0x11 is not lost.
REQ-035 SHALL cover flush: flush = 1 with main = 0x20, skid = 0x21 and in_valid = 1 carrying 0x22 -> next cycle out_valid = 0, allow_in = 1, none of 0x20..0x22 is ever output.
REQ-036 SHALL cover skid backpressure (PIPE_STAGE_SKID_EN): next_allow_in = 0 with 3 beats offered -> exactly 2 accepted, allow_in = 0; release -> beats exit in order, allow_in = 1 one cycle after the skid empties.
REQ-037 SHALL cover bubble: in_valid = 0 for one cycle between beats with next_allow_in = 1 -> out_valid shows exactly one low cycle, with no duplicate beat.
